// File: rtl/repeating_buffer_pkg.sv
// Shared types and constants for the triple-banked frame-replay buffer.
package repeating_buffer_pkg;

   localparam int DEFAULT_DATA_W = 17;
   localparam int DEFAULT_DEPTH  = 1024;
   localparam int BANK_COUNT     = 3;

   typedef logic [1:0] bank_t;

   // Returns the one bank (of 0..2) that is neither a nor b.
   function automatic bank_t other_bank(input bank_t a, input bank_t b);
      bank_t result;
      if (a != 2'd0 && b != 2'd0) begin
         result = 2'd0;
      end else if (a != 2'd1 && b != 2'd1) begin
         result = 2'd1;
      end else begin
         result = 2'd2;
      end
      return result;
   endfunction

endpackage

// File: rtl/repeating_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port, 3 banks deep.
module repeating_buffer_ram
   import repeating_buffer_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH) + 2
) (
   input  logic              i_clk,
   input  logic              i_wrEn,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [DATA_W-1:0] i_wrData,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [DATA_W-1:0] o_rdData
);

   logic [DATA_W-1:0] r_mem [BANK_COUNT*DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
      o_rdData <= r_mem[i_rdAddr];
   end

endmodule

// File: rtl/repeating_buffer.sv
// Captures sparse samples into DEPTH-sample frames and replays the newest
// complete frame every clock; three banks keep the playing frame untouched.
module repeating_buffer
   import repeating_buffer_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic              o_repeat
);

   localparam int               IDX_W    = $clog2(DEPTH);
   localparam int               ADDR_W   = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [IDX_W-1:0]  r_wrIdx;
   logic [IDX_W-1:0]  r_rdIdx;
   bank_t             r_fillBank;
   bank_t             r_playBank;
   bank_t             r_readyBank;
   logic              r_readyValid;
   logic              r_started;
   logic [ADDR_W-1:0] r_rdAddr;
   logic              r_s1Valid;
   logic              r_s1Last;
   logic              r_s1Repeat;
   logic              r_s2Valid;
   logic              r_s2Last;
   logic              r_s2Repeat;

   logic              w_complete;
   logic              w_boundary;
   logic              w_issue;
   logic              w_fresh;
   bank_t             w_nextPlay;
   logic [ADDR_W-1:0] w_wrAddr;
   logic [DATA_W-1:0] w_ramData;

   // Before the first start a boundary is simply "a ready frame exists".
   assign w_complete = i_valid && (r_wrIdx == LAST_IDX);
   assign w_boundary = r_started ? (r_rdIdx == '0) : r_readyValid;
   assign w_issue    = r_started || w_boundary;
   assign w_fresh    = w_boundary && (w_complete || r_readyValid);
   assign w_wrAddr   = {r_fillBank, r_wrIdx};

   always_comb begin
      w_nextPlay = r_playBank;
      if (w_boundary) begin
         if (w_complete) begin
            w_nextPlay = r_fillBank;
         end else if (r_readyValid) begin
            w_nextPlay = r_readyBank;
         end
      end
   end

   repeating_buffer_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk    (i_clk),
      .i_wrEn   (i_valid),
      .i_wrAddr (w_wrAddr),
      .i_wrData (i_data),
      .i_rdAddr (r_rdAddr),
      .o_rdData (w_ramData)
   );

   // Bank arbitration: a completion coinciding with a boundary bypasses the ready slot.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_wrIdx      <= '0;
         r_fillBank   <= 2'd0;
         r_playBank   <= 2'd2;
         r_readyBank  <= 2'd1;
         r_readyValid <= 1'b0;
      end else begin
         if (i_valid) begin
            r_wrIdx <= r_wrIdx + IDX_W'(1);
         end
         if (w_boundary && w_complete) begin
            r_playBank   <= r_fillBank;
            r_fillBank   <= r_playBank;
            r_readyValid <= 1'b0;
         end else if (w_boundary && r_readyValid) begin
            r_playBank   <= r_readyBank;
            r_readyValid <= 1'b0;
         end else if (w_complete) begin
            r_readyBank  <= r_fillBank;
            r_readyValid <= 1'b1;
            r_fillBank   <= other_bank(r_fillBank, r_playBank);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_started  <= 1'b0;
         r_rdIdx    <= '0;
         r_rdAddr   <= '0;
         r_s1Valid  <= 1'b0;
         r_s1Last   <= 1'b0;
         r_s1Repeat <= 1'b0;
         r_s2Valid  <= 1'b0;
         r_s2Last   <= 1'b0;
         r_s2Repeat <= 1'b0;
         o_valid    <= 1'b0;
         o_last     <= 1'b0;
         o_repeat   <= 1'b0;
         o_data     <= '0;
      end else begin
         r_s1Valid <= w_issue;
         if (w_issue) begin
            r_started <= 1'b1;
            r_rdAddr  <= {w_nextPlay, r_rdIdx};
            r_rdIdx   <= r_rdIdx + IDX_W'(1);
            r_s1Last  <= (r_rdIdx == LAST_IDX);
            if (w_boundary) begin
               r_s1Repeat <= !w_fresh;
            end
         end
         r_s2Valid  <= r_s1Valid;
         r_s2Last   <= r_s1Last;
         r_s2Repeat <= r_s1Repeat;
         o_valid    <= r_s2Valid;
         o_last     <= r_s2Valid && r_s2Last;
         o_repeat   <= r_s2Valid && r_s2Repeat;
         if (r_s2Valid) begin
            o_data <= w_ramData;
         end
      end
   end

endmodule

// File: tb/tb_repeating_buffer.sv
// Self-checking bench for repeating_buffer (DEPTH=8) against a frame-level reference model.
module tb_repeating_buffer;

   localparam int DATA_W = 17;
   localparam int DEPTH  = 8;

   logic              i_clk;
   logic              i_resetn;
   logic              i_valid;
   logic [DATA_W-1:0] i_data;
   logic              o_valid;
   logic [DATA_W-1:0] o_data;
   logic              o_last;
   logic              o_repeat;

   int compared   = 0;
   int mismatched = 0;
   int edgeNo     = 0;

   logic [DATA_W-1:0] fillBuf     [DEPTH];
   logic [DATA_W-1:0] latestFrame [DEPTH];
   logic [DATA_W-1:0] playFrame   [DEPTH];
   int  wrCount, latestId, frameCount, playId, rdIdx, startEdge;
   bit  haveLatest, started, playRepeat;

   bit                expValid  [4];
   bit                expLast   [4];
   bit                expRepeat [4];
   logic [DATA_W-1:0] expData   [4];

   int firstValidEdge = -1;
   int captureEdge    = 0;
   bit staleWatch     = 1'b1;
   bit sawNine        = 1'b0;
   int staleCount     = 0;
   int dataNext       = 1;
   int simEdge        = 0;

   repeating_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_valid  (i_valid),
      .i_data   (i_data),
      .o_valid  (o_valid),
      .o_data   (o_data),
      .o_last   (o_last),
      .o_repeat (o_repeat)
   );

   initial begin
      i_clk = 1'b1;
      forever #5 i_clk = ~i_clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edgeNo, observed, expected);
      end
   endtask

   task automatic modelReset();
      wrCount    = 0;
      haveLatest = 1'b0;
      started    = 1'b0;
      playId     = 0;
      rdIdx      = 0;
      for (int i = 0; i < 4; i++) begin
         expValid[i]  = 1'b0;
         expLast[i]   = 1'b0;
         expRepeat[i] = 1'b0;
         expData[i]   = '0;
      end
   endtask

   // One rising edge of the reference: capture, then decide what sample is issued.
   task automatic modelStep(input bit v, input logic [DATA_W-1:0] d);
      bit wasReady;
      int slot;
      wasReady = haveLatest;
      if (v) begin
         fillBuf[wrCount] = d;
         wrCount++;
         if (wrCount == DEPTH) begin
            latestFrame = fillBuf;
            haveLatest  = 1'b1;
            frameCount++;
            latestId    = frameCount;
            wrCount     = 0;
         end
      end
      slot = edgeNo % 4;
      expValid[slot]  = 1'b0;
      expLast[slot]   = 1'b0;
      expRepeat[slot] = 1'b0;
      expData[slot]   = '0;
      if (!started && wasReady) begin
         started   = 1'b1;
         rdIdx     = 0;
         startEdge = edgeNo;
      end
      if (started) begin
         if (rdIdx == 0) begin
            if (latestId != playId) begin
               playFrame  = latestFrame;
               playId     = latestId;
               playRepeat = 1'b0;
            end else begin
               playRepeat = 1'b1;
            end
         end
         expValid[slot]  = 1'b1;
         expData[slot]   = playFrame[rdIdx];
         expLast[slot]   = (rdIdx == DEPTH - 1);
         expRepeat[slot] = playRepeat;
         rdIdx = (rdIdx + 1) % DEPTH;
      end
   endtask

   task automatic checkCycle();
      int idx;
      idx = (edgeNo + 2) % 4;
      checkOutput("o_valid", 32'(o_valid), 32'(expValid[idx]));
      checkOutput("o_last", 32'(o_last), 32'(expLast[idx]));
      checkOutput("o_repeat", 32'(o_repeat), 32'(expRepeat[idx]));
      if (expValid[idx]) begin
         checkOutput("o_data", 32'(o_data), 32'(expData[idx]));
      end
      if (o_valid && firstValidEdge < 0) begin
         firstValidEdge = edgeNo;
      end
      if (staleWatch && o_valid) begin
         if (o_data == 17'd9) sawNine = 1'b1;
         if (sawNine && o_data >= 17'd1 && o_data <= 17'd8) staleCount++;
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d);
      i_valid = v;
      i_data  = d;
      @(posedge i_clk);
      edgeNo++;
      if (i_resetn) modelStep(v, d);
      else          modelReset();
      #1;
      checkCycle();
   endtask

   initial begin
      frameCount = 0;
      latestId   = 0;
      playRepeat = 1'b0;
      startEdge  = 0;
      i_resetn   = 1'b0;
      i_valid    = 1'b0;
      i_data     = '0;
      modelReset();
      #4;
      checkOutput("rst_valid", 32'(o_valid), 0);
      checkOutput("rst_last", 32'(o_last), 0);
      checkOutput("rst_repeat", 32'(o_repeat), 0);
      checkOutput("rst_data", 32'(o_data), 0);
      #1 i_resetn = 1'b1;

      // Sparse frames 1..8 and 9..16, one sample every 32 cycles.
      for (int s = 0; s < 2 * DEPTH; s++) begin
         applyStimulus(1'b1, DATA_W'(dataNext));
         dataNext++;
         if (s == DEPTH - 1) captureEdge = edgeNo;
         for (int k = 0; k < 31; k++) applyStimulus(1'b0, '0);
         if (s == DEPTH - 2) checkOutput("idle_after_7", 32'(o_valid), 0);
      end
      for (int k = 0; k < 24; k++) applyStimulus(1'b0, '0);
      checkOutput("first_latency", 32'(firstValidEdge - captureEdge), 3);
      checkOutput("frame2_seen", 32'(sawNine), 1);
      checkOutput("stale_frame1", 32'(staleCount), 0);
      staleWatch = 1'b0;

      // Last sample of the next frame lands exactly on a read boundary.
      for (int s = 0; s < DEPTH - 1; s++) begin
         applyStimulus(1'b1, DATA_W'(dataNext));
         dataNext++;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if ((edgeNo + 1 - startEdge) % DEPTH == 0) break;
         applyStimulus(1'b0, '0);
      end
      applyStimulus(1'b1, DATA_W'(dataNext));
      dataNext++;
      simEdge = edgeNo;
      applyStimulus(1'b0, '0);
      applyStimulus(1'b0, '0);
      checkOutput("sim_edges", 32'(edgeNo - simEdge), 2);
      checkOutput("sim_valid", 32'(o_valid), 1);
      checkOutput("sim_data", 32'(o_data), 32'(dataNext - DEPTH));
      checkOutput("sim_repeat", 32'(o_repeat), 0);
      for (int k = 0; k < 20; k++) applyStimulus(1'b0, '0);

      // Continuous input every cycle.
      for (int k = 0; k < 160; k++) begin
         applyStimulus(1'b1, DATA_W'(dataNext));
         dataNext++;
      end

      // Random valid pattern and data.
      for (int k = 0; k < 400; k++) begin
         applyStimulus($urandom_range(0, 3) == 0, DATA_W'($urandom));
      end

      // Mid-frame reset during playout.
      applyStimulus(1'b1, DATA_W'($urandom));
      #3 i_resetn = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(o_valid), 0);
      checkOutput("midrst_last", 32'(o_last), 0);
      checkOutput("midrst_repeat", 32'(o_repeat), 0);
      checkOutput("midrst_data", 32'(o_data), 0);
      modelReset();
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, DATA_W'($urandom));
      #2 i_resetn = 1'b1;
      firstValidEdge = -1;
      for (int s = 0; s < DEPTH; s++) begin
         applyStimulus(1'b1, DATA_W'(1000 + s));
         if (s == DEPTH - 1) captureEdge = edgeNo;
         for (int k = 0; k < 2; k++) applyStimulus(1'b0, '0);
         if (s == DEPTH - 2) checkOutput("postrst_idle", 32'(o_valid), 0);
      end
      for (int k = 0; k < 30; k++) applyStimulus(1'b0, '0);
      checkOutput("postrst_latency", 32'(firstValidEdge - captureEdge), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
